prot_limit_check_pipe: RTL and testbench

PROT_LIMIT_CHECK_PIPE -- requirements
Module: prot_limit_check_pipe

---
 rtl/prot_limit_check_pipe_if.sv | 27 ++
 rtl/prot_limit_check_pipe.sv | 104 ++++++++++
 tb/tb_prot_limit_check_pipe.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/prot_limit_check_pipe_if.sv
// prot_limit_check_pipe_if: request and result handshake bundle for prot_limit_check_pipe.
// The master side issues requests and accepts results; the slave side is the checker.
interface prot_limit_check_pipe_if #(
    parameter int WIDTH = 32,
    parameter int SEG_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] disp_imm;
    logic [WIDTH-1:0] calc_size;
    logic [3:0]       address_size;
    logic [SEG_W-1:0] seg_sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] end_addr;
    logic             prot_exc;

    modport master (
        output in_valid, disp_imm, calc_size, address_size, seg_sel, out_ready,
        input  in_ready, out_valid, end_addr, prot_exc
    );

    modport slave (
        input  in_valid, disp_imm, calc_size, address_size, seg_sel, out_ready,
        output in_ready, out_valid, end_addr, prot_exc
    );
endinterface

// File: rtl/prot_limit_check_pipe.sv
// prot_limit_check_pipe: 2-stage segment-limit check of the last byte address of an access.
// Define PROT_EXC_COUNT_EN to add a saturating 16-bit count of handed-off exceptions (exc_count).
module prot_limit_check_pipe #(
    parameter int WIDTH   = 32,
    parameter int NUM_SEG = 6,
    parameter int SEG_W   = 3
) (
    input  logic                   clk,
    input  logic                   clr,
    prot_limit_check_pipe_if.slave bus,
    input  logic                   lim_we,
    input  logic [SEG_W-1:0]       lim_idx,
    input  logic [WIDTH-1:0]       lim_data,
    input  logic                   sticky_clr,
    output logic                   exc_sticky
`ifdef PROT_EXC_COUNT_EN
    ,
    output logic [15:0]            exc_count
`endif
);
    // One slot per encodable index; slots at or above NUM_SEG are never written.
    localparam int NLIM = 2 ** SEG_W;

    logic [WIDTH-1:0] lim_q [NLIM];
    logic [WIDTH-1:0] lim_d [NLIM];
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH+1:0] sum_q, sum_d;
    logic [WIDTH-1:0] s1_lim_q, s1_lim_d;
    logic             s1_bad_q, s1_bad_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] end_addr_q, end_addr_d;
    logic             prot_exc_q, prot_exc_d;
    logic             exc_sticky_q, exc_sticky_d;
    logic             s1_adv, in_fire, exc_set;
    logic [2:0]       bytes_m1;

    assign bus.in_ready  = !s1_valid_q || s1_adv;
    assign bus.out_valid = s2_valid_q;
    assign bus.end_addr  = end_addr_q;
    assign bus.prot_exc  = prot_exc_q;
    assign exc_sticky    = exc_sticky_q;

    always_comb begin
        s1_adv       = s1_valid_q && (!s2_valid_q || bus.out_ready);
        in_fire      = bus.in_valid && bus.in_ready;
        exc_set      = s2_valid_q && bus.out_ready && prot_exc_q;
        bytes_m1     = bus.address_size[3] ? 3'd7 : bus.address_size[2] ? 3'd3 :
                       bus.address_size[1] ? 3'd1 : 3'd0;
        s1_valid_d   = in_fire || (s1_valid_q && !s1_adv);
        // Two extra bits keep the exact sum so a carry out of WIDTH flags a wrap.
        sum_d        = in_fire ? {2'b00, bus.disp_imm} + {2'b00, bus.calc_size} +
                       (WIDTH+2)'(bytes_m1) : sum_q;
        s1_lim_d     = in_fire ? lim_q[bus.seg_sel] : s1_lim_q;
        s1_bad_d     = in_fire ? (!$onehot(bus.address_size) ||
                       {1'b0, bus.seg_sel} >= (SEG_W+1)'(NUM_SEG)) : s1_bad_q;
        s2_valid_d   = s1_adv || (s2_valid_q && !bus.out_ready);
        end_addr_d   = s1_adv ? sum_q[WIDTH-1:0] : end_addr_q;
        prot_exc_d   = s1_adv ? (s1_bad_q || (|sum_q[WIDTH+1:WIDTH]) ||
                       sum_q[WIDTH-1:0] > s1_lim_q) : prot_exc_q;
        exc_sticky_d = exc_set || (exc_sticky_q && !sticky_clr);
        for (int i = 0; i < NLIM; i++)
            lim_d[i] = (lim_we && lim_idx == SEG_W'(i) && i < NUM_SEG) ? lim_data : lim_q[i];
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            s1_valid_q   <= 1'b0;
            sum_q        <= '0;
            s1_lim_q     <= '0;
            s1_bad_q     <= 1'b0;
            s2_valid_q   <= 1'b0;
            end_addr_q   <= '0;
            prot_exc_q   <= 1'b0;
            exc_sticky_q <= 1'b0;
            for (int i = 0; i < NLIM; i++) lim_q[i] <= '1;
        end else begin
            s1_valid_q   <= s1_valid_d;
            sum_q        <= sum_d;
            s1_lim_q     <= s1_lim_d;
            s1_bad_q     <= s1_bad_d;
            s2_valid_q   <= s2_valid_d;
            end_addr_q   <= end_addr_d;
            prot_exc_q   <= prot_exc_d;
            exc_sticky_q <= exc_sticky_d;
            lim_q        <= lim_d;
        end
    end

`ifdef PROT_EXC_COUNT_EN
    logic [15:0] exc_count_q, exc_count_d;

    assign exc_count = exc_count_q;

    always_comb begin
        exc_count_d = exc_set ? exc_count_q + {15'd0, exc_count_q != 16'hFFFF} :
                      sticky_clr ? 16'd0 : exc_count_q;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) exc_count_q <= '0;
        else      exc_count_q <= exc_count_d;
    end
`endif
endmodule

// File: tb/tb_prot_limit_check_pipe.sv
// tb_prot_limit_check_pipe: directed checks of latency, limit compare, wrap, backpressure,
// same-cycle limit write, sticky/counter behaviour and mid-flight reset.
module tb_prot_limit_check_pipe;
    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        lim_we = 1'b0;
    logic [2:0]  lim_idx = '0;
    logic [31:0] lim_data = '0;
    logic        sticky_clr = 1'b0;
    logic        exc_sticky;
`ifdef PROT_EXC_COUNT_EN
    logic [15:0] exc_count;
`endif
    int n_chk = 0;
    int n_pass = 0;
    int acc, got;
    logic [31:0] bp_d [4] = '{32'h100, 32'h200, 32'h300, 32'h400};

    prot_limit_check_pipe_if #(.WIDTH(32), .SEG_W(3)) bus ();

    prot_limit_check_pipe #(.WIDTH(32), .NUM_SEG(6), .SEG_W(3)) dut (
        .clk        (clk),
        .clr        (clr),
        .bus        (bus),
        .lim_we     (lim_we),
        .lim_idx    (lim_idx),
        .lim_data   (lim_data),
        .sticky_clr (sticky_clr),
        .exc_sticky (exc_sticky)
`ifdef PROT_EXC_COUNT_EN
        ,
        .exc_count  (exc_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        n_chk++;
        if (got_v === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic sclr_pulse;
        sticky_clr = 1'b1;
        cyc;
        sticky_clr = 1'b0;
    endtask

    // One request with no backpressure: accept, result two cycles later, hand-off.
    task automatic req(input string tag, input logic [31:0] d, input logic [31:0] c,
                       input logic [3:0] sz, input logic [2:0] sg, input logic [31:0] e_end,
                       input logic e_exc, input bit ce, input bit sclr);
        bus.disp_imm = d;
        bus.calc_size = c;
        bus.address_size = sz;
        bus.seg_sel = sg;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk({tag, "_ir"}, bus.in_ready, 1);
        cyc;
        bus.in_valid = 1'b0;
        lim_we = 1'b0;
        chk({tag, "_ov_early"}, bus.out_valid, 0);
        cyc;
        chk({tag, "_ov"}, bus.out_valid, 1);
        if (ce) chk({tag, "_end"}, bus.end_addr, e_end);
        chk({tag, "_exc"}, bus.prot_exc, e_exc);
        sticky_clr = sclr;
        cyc;
        sticky_clr = 1'b0;
        if (e_exc) chk({tag, "_sticky"}, exc_sticky, 1);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.disp_imm = '0;
        bus.calc_size = '0;
        bus.address_size = 4'b0001;
        bus.seg_sel = '0;
        bus.out_ready = 1'b0;
        cyc;
        cyc;
        chk("rst_ov", bus.out_valid, 0);
        chk("rst_end", bus.end_addr, 0);
        chk("rst_exc", bus.prot_exc, 0);
        chk("rst_sticky", exc_sticky, 0);
        clr = 1'b1;
        #1;
        chk("rst_ir", bus.in_ready, 1);

        lim_we = 1'b1; lim_idx = 3'd2; lim_data = 32'h0000_0FFF;
        cyc;
        lim_we = 1'b0;
        req("lim_edge", 32'hFF8, 32'h0, 4'b1000, 3'd2, 32'hFFF, 1'b0, 1'b1, 1'b0);
        chk("lim_edge_sticky", exc_sticky, 0);
        req("lim_over", 32'hFF9, 32'h0, 4'b1000, 3'd2, 32'h1000, 1'b1, 1'b1, 1'b0);
`ifdef PROT_EXC_COUNT_EN
        chk("cnt_1", exc_count, 1);
`endif
        sclr_pulse;
        chk("sclr_sticky", exc_sticky, 0);
`ifdef PROT_EXC_COUNT_EN
        chk("sclr_cnt", exc_count, 0);
`endif
        req("b1_edge", 32'hFFE, 32'h1, 4'b0001, 3'd2, 32'hFFF, 1'b0, 1'b1, 1'b0);
        req("b4_calc", 32'h800, 32'h7FC, 4'b0100, 3'd2, 32'hFFF, 1'b0, 1'b1, 1'b0);
        chk("noexc_sticky", exc_sticky, 0);
        req("wrap", 32'hFFFF_FFFE, 32'h1, 4'b0010, 3'd0, 32'h0, 1'b1, 1'b1, 1'b0);
        req("nonhot", 32'h10, 32'h0, 4'b0011, 3'd0, 32'h0, 1'b1, 1'b0, 1'b0);
        req("seg_oor", 32'h0, 32'h0, 4'b0001, 3'd7, 32'h0, 1'b1, 1'b1, 1'b0);
`ifdef PROT_EXC_COUNT_EN
        chk("cnt_3", exc_count, 3);
`endif
        sclr_pulse;
        chk("sclr2_sticky", exc_sticky, 0);
        req("set_wins", 32'h0, 32'h0, 4'b0001, 3'd7, 32'h0, 1'b1, 1'b1, 1'b1);
`ifdef PROT_EXC_COUNT_EN
        chk("cnt_setwins", exc_count, 1);
`endif
        sclr_pulse;

        // Four back-to-back requests while the consumer stalls three cycles.
        acc = 0;
        got = 0;
        bus.calc_size = '0;
        bus.address_size = 4'b0001;
        bus.seg_sel = '0;
        for (int t = 0; t < 40 && got < 4; t++) begin
            bus.in_valid = acc < 4;
            bus.disp_imm = acc < 4 ? bp_d[acc] : 32'h0;
            bus.out_ready = t >= 5;
            #1;
            if (t == 1) chk("bp_ir1", bus.in_ready, 1);
            if (t >= 2 && t <= 4) begin
                chk("bp_ir0", bus.in_ready, 0);
                chk("bp_hold_ov", bus.out_valid, 1);
                chk("bp_hold_end", bus.end_addr, 32'h100);
                chk("bp_hold_exc", bus.prot_exc, 0);
            end
            if (bus.out_valid && bus.out_ready) begin
                chk("bp_end", bus.end_addr, bp_d[got]);
                got++;
            end
            if (bus.in_valid && bus.in_ready) acc++;
            cyc;
        end
        bus.in_valid = 1'b0;
        chk("bp_got", got, 4);
        chk("bp_acc", acc, 4);
        chk("bp_nodup", bus.out_valid, 0);
        chk("bp_sticky", exc_sticky, 0);

        lim_we = 1'b1; lim_idx = 3'd1; lim_data = 32'h10;
        req("limwr_old", 32'h20, 32'h0, 4'b0001, 3'd1, 32'h20, 1'b0, 1'b1, 1'b0);
        req("limwr_new", 32'h20, 32'h0, 4'b0001, 3'd1, 32'h20, 1'b1, 1'b1, 1'b0);
`ifdef PROT_EXC_COUNT_EN
        chk("cnt_limwr", exc_count, 1);
`endif

        // Two requests in flight when reset hits.
        bus.out_ready = 1'b1;
        bus.disp_imm = 32'h0; bus.seg_sel = 3'd7; bus.in_valid = 1'b1;
        cyc;
        bus.disp_imm = 32'h40; bus.seg_sel = 3'd0;
        cyc;
        bus.in_valid = 1'b0;
        #1;
        chk("fl_ov", bus.out_valid, 1);
        clr = 1'b0;
        #1;
        chk("fl_rst_ov", bus.out_valid, 0);
        chk("fl_rst_end", bus.end_addr, 0);
        chk("fl_rst_exc", bus.prot_exc, 0);
        chk("fl_rst_sticky", exc_sticky, 0);
`ifdef PROT_EXC_COUNT_EN
        chk("fl_rst_cnt", exc_count, 0);
`endif
        clr = 1'b1;
        #1;
        chk("fl_ir", bus.in_ready, 1);
        for (int k = 0; k < 5; k++) begin
            cyc;
            chk("fl_no_out", bus.out_valid, 0);
        end
`ifdef PROT_EXC_COUNT_EN
        chk("fl_cnt_after", exc_count, 0);
`endif
        req("rst_lim", 32'h20, 32'h0, 4'b0001, 3'd1, 32'h20, 1'b0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
